oled_disp_sched: RTL
====================

Name: oled_disp_sched

Overview:
- Owns the single IIC write channel to the SSD1306 OLED (slave byte 8'h78) and shares it between display tasks.
- Boot sequence: panel init, then full clear, then static font/label draw.
- After boot, it round-robins NUM_DYN dynamic-value refresh clients (temperature, humidity, bpm digits).
- Sits between the task modules (init, clear, show-font, digit writers) and the IIC byte writer.

Parameters:
- NUM_DYN, 3: number of dynamic refresh clients (1..8).
- TIMEOUT_CYC, 5_000_000: sys_clk cycles without iic_write_done, while granted, before abort.
- REDRAW_CYC, 50_000_000: periodic full-redraw interval (only with the optional feature).

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- init_req  out  1  grant/request to init task
- init_data  in  24  init task IIC word {slave, ctrl, byte}
- init_finish  in  1  init task done pulse
- clear_req  out  1  grant to clear task
- clear_data  in  24  clear task IIC word
- clear_finish  in  1  clear done pulse
- font_req  out  1  grant to show-font task
- font_data  in  24  show-font IIC word
- font_finish  in  1  show-font done pulse
- dyn_pend  in  NUM_DYN  level: client k has a refresh pending
- dyn_data  in  24*NUM_DYN  packed IIC words, client k at [24k+23:24k]
- dyn_finish  in  NUM_DYN  done pulses
- dyn_grant  out  NUM_DYN  one-hot grant
- task_write_done  out  1  iic_write_done routed to the granted task only
- iic_req  out  1  write request to IIC writer
- iic_data  out  24  muxed IIC word
- iic_write_done  in  1  one-cycle pulse: current word sent
- busy  out  1  state != S_RUN
- err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n low at a sys_clk edge) takes priority over everything:
  - State goes to S_INIT; watchdog cleared; rr pointer = 0; err = 0.
  - All grant/req outputs and task_write_done are registered, reset to 0.
  - Reset mid-transfer drops grants the following cycle.
- States:
  - S_INIT: init_req=1; exit on init_finish -> S_CLEAR.
  - S_CLEAR: clear_req=1; exit on clear_finish -> S_FONT.
  - S_FONT: font_req=1; exit on font_finish -> S_RUN.
  - S_RUN: no grant. If any dyn_pend is set, pick the first set bit at or after the rr pointer (wrapping), then go to S_DYN. Otherwise stay.
  - S_DYN: dyn_grant[k]=1; exit on dyn_finish[k] -> S_RUN, with rr pointer = k+1 (wrapping at NUM_DYN).
- Grant timing:
  - Grant outputs are registered and asserted the cycle after entering the state.
  - A finish pulse deasserts the grant on the next edge; there is no gap cycle between tasks.
  - From S_RUN with a pending client, grant appears 1 cycle after the pend is sampled.
- Data path:
  - iic_req is high exactly when any grant is high.
  - iic_data is the combinational mux of the granted client's data, or 24'h0 when none is granted.
  - task_write_done = iic_write_done & (any grant).
- Ignored and simultaneous events:
  - Finish pulses from non-granted tasks are ignored; dyn_pend of a non-selected client is held off until its turn.
  - If dyn_finish and a new dyn_pend arrive in the same cycle, the state returns to S_RUN first; no back-to-back grant in the same cycle.
- Watchdog:
  - A counter runs while any grant is high and clears on iic_write_done or a state change.
  - Reaching TIMEOUT_CYC-1 sets err=1 and drops all grants, then goes to S_INIT to re-init the panel.
  - err is cleared only by reset.
- Counter widths: $clog2 of the parameter values; the rr pointer wraps modulo NUM_DYN.

Optional Feature:
- Macro: OLED_PERIODIC_REDRAW_EN.
- With the macro defined:
  - A free-running counter of REDRAW_CYC cycles sets a redraw_pend flag.
  - In S_RUN, redraw_pend has priority over dyn_pend and goes to S_CLEAR; redraw_pend clears on entry.
  - The flag is never lost while in S_DYN.
- Without it: the counter and flag are absent, and S_RUN only serves dyn_pend.

Decomposition:
- Shared package oled_pkg:
  - State enum (S_INIT, S_CLEAR, S_FONT, S_RUN, S_DYN).
  - OLED_SLAVE_ADDR = 8'h78, CTRL_CMD = 8'h00, CTRL_DATA = 8'h40.
  - IIC word width 24.
- One sub-module, oled_rr_arb: a NUM_DYN-wide round-robin pick. Inputs: pend vector and pointer. Outputs: one-hot grant and a valid flag. Purely combinational.

Test Plan:
1. Reset then boot: pulse init_finish at t0+20, clear_finish at +40, font_finish at +60. Required: init_req, clear_req and font_req are each high in sequence with no overlap; busy=0 from the cycle after font_finish.
2. Round-robin: in S_RUN, dyn_pend=3'b111 held, each client finishes after 5 words. Required: grants go 001, 010, 100, 001; iic_data equals that client's slice.
3. Routing: while client 1 is granted, pulse iic_write_done. Required: task_write_done=1. Pulse dyn_finish[0]: ignored, grant stays 010.
4. Watchdog with TIMEOUT_CYC=100 and client granted, no write_done for 100 cycles. Required: err=1, grants drop, init_req reasserts.
5. Reset mid-S_DYN: assert rst_n=0 for one edge. Required: dyn_grant=0 and iic_req=0 after that edge, state S_INIT.
6. With OLED_PERIODIC_REDRAW_EN and REDRAW_CYC=200, dyn_pend=3'b001 pending at expiry. Required: S_CLEAR then S_FONT are served before client 0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 OLED display scheduler: state codes,
// IIC word layout constants and a one-hot to index helper.
package oled_pkg;

  localparam int IIC_W = 24;

  localparam logic [7:0] OLED_SLAVE_ADDR = 8'h78;
  localparam logic [7:0] CTRL_CMD        = 8'h00;
  localparam logic [7:0] CTRL_DATA       = 8'h40;

  typedef logic [2:0] state_t;

  localparam state_t S_INIT  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_FONT  = 3'd2;
  localparam state_t S_RUN   = 3'd3;
  localparam state_t S_DYN   = 3'd4;

  // Index of the set bit of a one-hot vector of up to 8 clients.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/oled_rr_arb.sv
// Combinational round-robin pick over NUM_DYN pending clients: the first set
// bit of pend at or after ptr, wrapping. Rotation keeps all indices constant.
module oled_rr_arb #(
  parameter int NUM_DYN = 3,
  localparam int PW = (NUM_DYN > 1) ? $clog2(NUM_DYN) : 1
) (
  input  logic [NUM_DYN-1:0] pend,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_DYN-1:0] grant,
  output logic               valid
);

  logic [2*NUM_DYN-1:0] rot_dbl;
  logic [NUM_DYN-1:0]   rot;
  logic [NUM_DYN-1:0]   rot_pick;
  logic [2*NUM_DYN-1:0] back_dbl;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_dbl  = {pend, pend} >> ptr;
    rot      = rot_dbl[NUM_DYN-1:0];
    rot_pick = '0;
    valid    = 1'b0;
    for (int i = 0; i < NUM_DYN; i++) begin
      if (!valid && rot[i]) begin
        rot_pick[i] = 1'b1;
        valid       = 1'b1;
      end
    end
    back_dbl = {rot_pick, rot_pick} << ptr;
    grant    = back_dbl[2*NUM_DYN-1:NUM_DYN];
  end

endmodule

// File: rtl/oled_disp_sched.sv
// Owner of the single IIC write channel to the SSD1306 panel. Boots the panel
// (init, clear, font draw), then round-robins the dynamic refresh clients.
// Optional feature macro OLED_PERIODIC_REDRAW_EN adds a periodic full redraw.
// Handshake: a task owns the channel while its grant is high; iic_req mirrors
// any grant, iic_data carries the owner's word, the owner sees only its own
// write-done pulse (one cycle late, registered) and ends with a finish pulse.
module oled_disp_sched
  import oled_pkg::*;
#(
  parameter int NUM_DYN     = 3,
  parameter int TIMEOUT_CYC = 5_000_000
`ifdef OLED_PERIODIC_REDRAW_EN
  ,parameter int REDRAW_CYC = 50_000_000
`endif
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  output logic                     init_req,
  input  logic [IIC_W-1:0]         init_data,
  input  logic                     init_finish,
  output logic                     clear_req,
  input  logic [IIC_W-1:0]         clear_data,
  input  logic                     clear_finish,
  output logic                     font_req,
  input  logic [IIC_W-1:0]         font_data,
  input  logic                     font_finish,
  input  logic [NUM_DYN-1:0]       dyn_pend,
  input  logic [IIC_W*NUM_DYN-1:0] dyn_data,
  input  logic [NUM_DYN-1:0]       dyn_finish,
  output logic [NUM_DYN-1:0]       dyn_grant,
  output logic                     task_write_done,
  output logic                     iic_req,
  output logic [IIC_W-1:0]         iic_data,
  input  logic                     iic_write_done,
  output logic                     busy,
  output logic                     err,
  output state_t                   fsm_state
);

  localparam int PW = (NUM_DYN > 1) ? $clog2(NUM_DYN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             state, next_state;
  logic [PW-1:0]      rr_ptr, ptr_next;
  logic [TW-1:0]      wd_cnt;
  logic [NUM_DYN-1:0] arb_grant;
  logic               arb_valid;
  logic               dyn_done, any_grant, timeout;

  oled_rr_arb #(.NUM_DYN(NUM_DYN)) u_arb (
    .pend  (dyn_pend),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign dyn_done  = |(dyn_finish & dyn_grant);
  assign any_grant = init_req | clear_req | font_req | (|dyn_grant);
  assign timeout   = any_grant && !iic_write_done && (next_state == state) &&
                     (wd_cnt == TW'(TIMEOUT_CYC - 1));
  assign busy      = (state != S_RUN);
  assign fsm_state = state;

`ifdef OLED_PERIODIC_REDRAW_EN
  localparam int RW = (REDRAW_CYC > 1) ? $clog2(REDRAW_CYC) : 1;
  logic [RW-1:0] redraw_cnt;
  logic          redraw_pend;

  // Free-running redraw timer; the flag survives until S_RUN acts on it.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      redraw_cnt  <= '0;
      redraw_pend <= 1'b0;
    end else if (redraw_cnt == RW'(REDRAW_CYC - 1)) begin
      redraw_cnt  <= '0;
      redraw_pend <= 1'b1;
    end else begin
      redraw_cnt <= redraw_cnt + RW'(1);
      if (state == S_RUN && next_state == S_CLEAR) redraw_pend <= 1'b0;
    end
  end
`endif

  // Next-state decode; finish pulses count only from the granted task.
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  if (init_finish && init_req)   next_state = S_CLEAR;
      S_CLEAR: if (clear_finish && clear_req) next_state = S_FONT;
      S_FONT:  if (font_finish && font_req)   next_state = S_RUN;
      S_RUN: begin
`ifdef OLED_PERIODIC_REDRAW_EN
        if (redraw_pend) next_state = S_CLEAR;
        else
`endif
        if (arb_valid) next_state = S_DYN;
      end
      S_DYN:   if (dyn_done) next_state = S_RUN;
      default: next_state = S_INIT;
    endcase
  end

  // Pointer advances to the client after the one that just finished.
  always_comb begin
    int k;
    k = int'(onehot_to_idx(8'(dyn_grant))) + 1;
    ptr_next = (k >= NUM_DYN) ? '0 : PW'(k);
  end

  // State, grants and routed done; grants follow the state being entered.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state           <= S_INIT;
      rr_ptr          <= '0;
      err             <= 1'b0;
      init_req        <= 1'b0;
      clear_req       <= 1'b0;
      font_req        <= 1'b0;
      dyn_grant       <= '0;
      iic_req         <= 1'b0;
      task_write_done <= 1'b0;
    end else if (timeout) begin
      state           <= S_INIT;
      err             <= 1'b1;
      init_req        <= 1'b0;
      clear_req       <= 1'b0;
      font_req        <= 1'b0;
      dyn_grant       <= '0;
      iic_req         <= 1'b0;
      task_write_done <= 1'b0;
    end else begin
      state     <= next_state;
      init_req  <= (next_state == S_INIT);
      clear_req <= (next_state == S_CLEAR);
      font_req  <= (next_state == S_FONT);
      if (next_state != S_DYN)  dyn_grant <= '0;
      else if (state == S_RUN)  dyn_grant <= arb_grant;
      iic_req         <= (next_state != S_RUN);
      task_write_done <= iic_write_done & any_grant;
      if (state == S_DYN && dyn_done) rr_ptr <= ptr_next;
    end
  end

  // Watchdog: counts granted cycles without progress.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) wd_cnt <= '0;
    else if (timeout || !any_grant || iic_write_done || next_state != state)
      wd_cnt <= '0;
    else wd_cnt <= wd_cnt + TW'(1);
  end

  // Route the granted task's word to the IIC writer.
  always_comb begin
    iic_data = '0;
    if (init_req)       iic_data = init_data;
    else if (clear_req) iic_data = clear_data;
    else if (font_req)  iic_data = font_data;
    else begin
      for (int k = 0; k < NUM_DYN; k++) begin
        if (dyn_grant[k]) iic_data = dyn_data[k*IIC_W +: IIC_W];
      end
    end
  end

endmodule
